// File: rtl/inst_mem.sv
// inst_mem: loadable instruction memory for the fetch stage.
// A program is streamed in through a valid/ready port, and its committed
// length bounds every later fetch. Fetches read with one registered cycle of
// latency. Any address at or beyond the program length returns END_WORD, so
// the core halts on short or empty programs.
module inst_mem #(
  parameter int unsigned    A        = 16,
  parameter int unsigned    W        = 9,
  parameter int unsigned    DEPTH    = 256,
  parameter logic [W-1:0]   END_WORD = '1,
  parameter int unsigned    LW       = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          load_start,
  input  logic          load_valid,
  input  logic [W-1:0]  load_data,
  output logic          load_ready,
  input  logic          load_done,
  output logic          load_overflow,
  output logic          loading,
  output logic [LW-1:0] prog_len,
  input  logic          fetch_en,
  input  logic [A-1:0]  InstAddress,
  output logic [W-1:0]  InstOut,
  output logic          inst_valid
);

  // Word-index width. Keep it at least one bit so that DEPTH = 1 still works.
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Common width for comparing the address against the length.
  localparam int unsigned CW = (A > LW) ? A : LW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [1:0]    state;
  logic [LW-1:0] count;
  logic [W-1:0]  mem [DEPTH];
  logic          accept;
  logic          in_range;

  // Load handshake and the fetch bounds check.
  // A word that arrives in the same cycle as load_start is dropped, because
  // the restart discards everything loaded so far.
  always_comb begin
    loading    = (state == S_LOAD);
    load_ready = loading && (count < LW'(DEPTH));
    accept     = load_ready && load_valid && !load_start;
    in_range   = CW'(InstAddress) < CW'(prog_len);
  end

  // Memory write port. The array has no reset; a length of zero hides stale contents.
  always_ff @(posedge CLK) begin
    if (!Reset && accept) begin
      mem[count[AW-1:0]] <= load_data;
    end
  end

  // State machine, load counter, committed length and the registered fetch.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state         <= S_IDLE;
      count         <= '0;
      prog_len      <= '0;
      load_overflow <= 1'b0;
      inst_valid    <= 1'b0;
      InstOut       <= END_WORD;
    end else begin
      inst_valid <= 1'b0;
      if (fetch_en && (state != S_LOAD)) begin
        inst_valid <= 1'b1;
        // in_range implies InstAddress < DEPTH, so the truncated index is exact.
        InstOut    <= in_range ? mem[InstAddress[AW-1:0]] : END_WORD;
      end

      if (load_start) begin
        state         <= S_LOAD;
        count         <= '0;
        prog_len      <= '0;
        load_overflow <= 1'b0;
      end else if (state == S_LOAD) begin
        if (accept) begin
          count <= count + LW'(1);
        end else if (load_valid) begin
          load_overflow <= 1'b1;
        end
        if (load_done) begin
          // Commit the length. It includes a word accepted in this same cycle.
          prog_len <= count + LW'(accept);
          state    <= S_RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_mem.sv
// tb_inst_mem: directed test of inst_mem. Two instances share every input.
// u0 (DEPTH=256) is checked on every cycle against a queue-based model.
// u1 (DEPTH=4) is checked for overflow behaviour with literal expectations.
module tb_inst_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        ls, lv, ld, fen;
  logic [8:0]  data;
  logic [15:0] addr;

  logic        ready0, ovf0, loading0, val0;
  logic [8:0]  len0, out0;
  logic        ready1, ovf1, loading1, val1;
  logic [2:0]  len1;
  logic [8:0]  out1;

  int checks   = 0;
  int failures = 0;

  inst_mem #(.A(16), .W(9), .DEPTH(256)) u0 (
    .CLK(clk), .Reset(rst), .load_start(ls), .load_valid(lv), .load_data(data),
    .load_ready(ready0), .load_done(ld), .load_overflow(ovf0), .loading(loading0),
    .prog_len(len0), .fetch_en(fen), .InstAddress(addr), .InstOut(out0),
    .inst_valid(val0)
  );

  inst_mem #(.A(16), .W(9), .DEPTH(4)) u1 (
    .CLK(clk), .Reset(rst), .load_start(ls), .load_valid(lv), .load_data(data),
    .load_ready(ready1), .load_done(ld), .load_overflow(ovf1), .loading(loading1),
    .prog_len(len1), .fetch_en(fen), .InstAddress(addr), .InstOut(out1),
    .inst_valid(val1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model of u0: queues hold the words of the load in progress and of the
  // committed program. m_mode is 0 = idle, 1 = loading, 2 = running.
  logic [8:0] m_pend[$];
  logic [8:0] m_prog[$];
  int         m_mode  = 0;
  bit         m_ovf   = 0;
  bit         e_valid = 0;
  bit         started = 0;
  logic [8:0] e_out   = 9'h1FF;

  always @(posedge clk) begin
    if (rst) begin
      started = 1;
      m_mode  = 0;
      m_pend.delete();
      m_prog.delete();
      m_ovf   = 0;
      e_valid = 0;
      e_out   = 9'h1FF;
    end else begin
      e_valid = fen && (m_mode != 1);
      if (e_valid) e_out = (int'(addr) < m_prog.size()) ? m_prog[addr] : 9'h1FF;
      if (ls) begin
        m_mode = 1;
        m_pend.delete();
        m_prog.delete();
        m_ovf  = 0;
      end else if (m_mode == 1) begin
        if (lv) begin
          if (m_pend.size() < 256) m_pend.push_back(data);
          else m_ovf = 1;
        end
        if (ld) begin
          m_prog = m_pend;
          m_mode = 2;
        end
      end
    end
  end

  // Compare u0 against the model on every cycle once reset has been seen.
  always @(negedge clk) begin
    if (started) begin
      chk("m_inst_valid", 32'(val0), 32'(e_valid));
      chk("m_InstOut", 32'(out0), 32'(e_out));
      chk("m_loading", 32'(loading0), 32'(m_mode == 1));
      chk("m_prog_len", 32'(len0), 32'(m_prog.size()));
      chk("m_load_overflow", 32'(ovf0), 32'(m_ovf));
      chk("m_load_ready", 32'(ready0), 32'((m_mode == 1) && (m_pend.size() < 256)));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic issue(input logic [15:0] a);
    fen  = 1'b1;
    addr = a;
    step();
    fen  = 1'b0;
  endtask

  task automatic put(input logic [8:0] d);
    lv   = 1'b1;
    data = d;
    step();
    lv   = 1'b0;
  endtask

  logic [8:0] w8 [8] = '{9'h03F, 9'h100, 9'h051, 9'h060, 9'h0B6, 9'h00C, 9'h022, 9'h0C8};

  initial begin
    rst = 1'b1; ls = 1'b0; lv = 1'b0; ld = 1'b0; fen = 1'b0; data = '0; addr = '0;
    step(); step();
    rst = 1'b0;

    // Reset state
    chk("rst_inst_valid", 32'(val0), 0);
    chk("rst_InstOut", 32'(out0), 32'h1FF);
    chk("rst_prog_len", 32'(len0), 0);
    chk("rst_loading", 32'(loading0), 0);
    chk("rst_load_ready", 32'(ready0), 0);
    chk("rst_overflow", 32'(ovf0), 0);

    // Empty program: every fetch halts
    issue(16'd0);      chk("empty_a0_valid", 32'(val0), 1); chk("empty_a0", 32'(out0), 32'h1FF);
    issue(16'd5);      chk("empty_a5_valid", 32'(val0), 1); chk("empty_a5", 32'(out0), 32'h1FF);
    issue(16'hFFFF);   chk("empty_aFFFF_valid", 32'(val0), 1); chk("empty_aFFFF", 32'(out0), 32'h1FF);
    step();
    chk("idle_no_fetch_valid", 32'(val0), 0);

    // Eight-word load, then a back-to-back fetch burst
    ls = 1'b1; step(); ls = 1'b0;
    chk("load_ready_on_entry", 32'(ready0), 1);
    chk("loading_on_entry", 32'(loading0), 1);
    for (int i = 0; i < 8; i++) put(w8[i]);
    ld = 1'b1; step(); ld = 1'b0;
    chk("len8", 32'(len0), 8);
    chk("run_loading", 32'(loading0), 0);
    for (int i = 0; i < 9; i++) begin
      fen = 1'b1; addr = 16'(i);
      step();
      chk("burst_valid", 32'(val0), 1);
      chk("burst_word", 32'(out0), (i < 8) ? 32'(w8[i]) : 32'h1FF);
    end
    fen = 1'b0;
    step();
    chk("hold_valid", 32'(val0), 0);
    chk("hold_word", 32'(out0), 32'h1FF);

    // Sparse load_valid, with load_done coinciding with the third word
    ls = 1'b1; step(); ls = 1'b0;
    put(9'h111); step();
    put(9'h122); step();
    lv = 1'b1; data = 9'h133; ld = 1'b1; step(); lv = 1'b0; ld = 1'b0;
    chk("len3", 32'(len0), 3);
    issue(16'd2); chk("len3_a2", 32'(out0), 32'h133);
    issue(16'd3); chk("len3_a3", 32'(out0), 32'h1FF);

    // Six words offered to the four-word instance
    ls = 1'b1; step(); ls = 1'b0;
    for (int i = 0; i < 6; i++) begin
      put(9'h040 + 9'(i));
      if (i == 2) chk("d4_ready_before_full", 32'(ready1), 1);
      if (i == 3) chk("d4_ready_after_full", 32'(ready1), 0);
    end
    chk("d4_overflow", 32'(ovf1), 1);
    ld = 1'b1; step(); ld = 1'b0;
    chk("d4_len", 32'(len1), 4);
    chk("d256_len6", 32'(len0), 6);
    issue(16'd3); chk("d4_a3", 32'(out1), 32'h043); chk("d256_a3", 32'(out0), 32'h043);
    issue(16'd4); chk("d4_a4", 32'(out1), 32'h1FF); chk("d256_a4", 32'(out0), 32'h044);

    // Restart via load_start together with load_done while overflowed mid-load
    ls = 1'b1; step(); ls = 1'b0;
    for (int i = 0; i < 5; i++) put(9'h0A0 + 9'(i));
    chk("d4_overflow_pre", 32'(ovf1), 1);
    ls = 1'b1; ld = 1'b1; step(); ls = 1'b0; ld = 1'b0;
    chk("restart_loading", 32'(loading1), 1);
    chk("restart_overflow", 32'(ovf1), 0);
    chk("restart_len", 32'(len1), 0);
    put(9'h155); put(9'h166);
    ld = 1'b1; step(); ld = 1'b0;
    chk("restart_len1", 32'(len1), 2);
    chk("restart_len0", 32'(len0), 2);
    chk("restart_ovf_after", 32'(ovf1), 0);
    issue(16'd0); chk("restart_a0", 32'(out1), 32'h155); chk("restart_a0_d256", 32'(out0), 32'h155);
    issue(16'd1); chk("restart_a1", 32'(out1), 32'h166);
    issue(16'd2); chk("restart_a2", 32'(out1), 32'h1FF); chk("restart_a2_d256", 32'(out0), 32'h1FF);

    // Reset in the middle of a load
    ls = 1'b1; step(); ls = 1'b0;
    for (int i = 0; i < 5; i++) put(9'h0F0 + 9'(i));
    rst = 1'b1; step(); rst = 1'b0;
    chk("midrst_loading", 32'(loading0), 0);
    chk("midrst_len", 32'(len0), 0);
    issue(16'd0); chk("midrst_a0_valid", 32'(val0), 1); chk("midrst_a0", 32'(out0), 32'h1FF);

    // A fetch during LOAD is ignored
    ls = 1'b1; step(); ls = 1'b0;
    issue(16'd0);
    chk("load_fetch_valid", 32'(val0), 0);
    chk("load_fetch_hold", 32'(out0), 32'h1FF);

    // Commit an empty load
    ld = 1'b1; step(); ld = 1'b0;
    chk("empty_load_len", 32'(len0), 0);
    issue(16'd0); chk("empty_load_a0", 32'(out0), 32'h1FF);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_mem.md
# inst_mem

Parametrised, loadable instruction memory for the core's fetch stage. It replaces a hard-coded instruction ROM with a synchronous RAM. The program is streamed in through a valid/ready load port and then fetched with one-cycle registered latency. Any fetch beyond the loaded program length returns the END_WORD halt instruction, so the core stops cleanly on under-length or empty programs.

## Interface
- A, 16: fetch address width.
- W, 9: instruction width.
- DEPTH, 256: number of instruction words; must satisfy 1 ≤ DEPTH ≤ 2**A.
- END_WORD, all ones (W bits): halt instruction returned for unloaded or out-of-range addresses.
- LW = $clog2(DEPTH+1): width of the length and count fields.

- CLK  in  1  single clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high.
- load_start  in  1  begin a new program load; restarts a load already in progress.
- load_valid  in  1  load_data is valid this cycle.
- load_data  in  W  instruction word to append.
- load_ready  out  1  memory can accept a word this cycle.
- load_done  in  1  end the load and commit the program length.
- load_overflow  out  1  sticky flag: a word was offered while the memory was full.
- loading  out  1  high while in the LOAD state.
- prog_len  out  LW  committed program length in words.
- fetch_en  in  1  request a fetch at InstAddress.
- InstAddress  in  A  fetch address.
- InstOut  out  W  fetched instruction (registered).
- inst_valid  out  1  InstOut was produced by a fetch issued in the previous cycle.

## Operation
- The state machine has three states: IDLE, LOAD, RUN. Reset enters IDLE.
- Reset values:
  - prog_len = 0, internal load count = 0.
  - load_overflow = 0, loading = 0, load_ready = 0.
  - inst_valid = 0, InstOut = END_WORD.
- Memory array contents are not cleared by Reset. They become unreachable because prog_len = 0.
- IDLE:
  - load_start moves to LOAD.
  - Fetches are served, and every fetch returns END_WORD.
- LOAD:
  - Entry via load_start clears the count, prog_len and load_overflow.
  - load_ready = (count < DEPTH).
  - A word is accepted when load_valid and load_ready are both high. It is written to mem[count], and count increments by 1.
  - load_valid while count == DEPTH drops the word and sets load_overflow.
  - load_done commits prog_len = count and moves to RUN.
  - loading = 1 in this state.
- RUN:
  - load_start returns to LOAD.
  - load_done is ignored.
  - Fetches are served from memory.
- Simultaneous events:
  - load_valid and load_done in the same cycle: the word is accepted first, so prog_len includes it.
  - load_start together with load_done, in any state: load_start wins, and the next state is LOAD with count = 0.
  - load_start during LOAD: the load restarts from address 0 and any words already written are discarded logically.
- Fetch rules:
  - A fetch_en in IDLE or RUN registers InstOut on the next edge:
    - mem[InstAddress] when InstAddress < prog_len;
    - END_WORD otherwise, including InstAddress ≥ DEPTH.
  - The address comparison is unsigned and zero-extended to max(A, LW) bits. No wrap-around.
  - fetch_en in LOAD is ignored: inst_valid = 0 and InstOut holds its value.
  - With fetch_en low, inst_valid = 0 and InstOut holds its value.

## Timing
- Fetch latency is 1 cycle: address and fetch_en at edge N give InstOut and inst_valid after edge N+1. Back-to-back fetches sustain 1 instruction per cycle.
- load_ready is combinational from the state and count. It is high in the same cycle the LOAD state begins (the cycle after load_start).
- Accepted words are counted at the edge; the last accepted word sets load_ready low after that edge.
- prog_len and the RUN state become visible the cycle after load_done. A fetch issued in that cycle sees the new program.
- Reset mid-load: the next cycle is IDLE with prog_len = 0, and partial load data is never fetchable.
- Throughput: one load word per cycle while load_ready is high.

## Test plan
- Reset with no load, fetch addresses 0, 5 and 0xFFFF → inst_valid = 1 one cycle later, and InstOut = 9'h1FF for each.
- Load 8 words 0x03F, 0x100, 0x051, 0x060, 0x0B6, 0x00C, 0x022, 0x0C8, then load_done → prog_len = 8. Fetching 0..7 returns those words in order at 1/cycle. Fetching 8 returns 0x1FF.
- Load with load_valid toggled every other cycle, and load_done asserted in the same cycle as the 3rd word → prog_len = 3, and address 2 returns the 3rd word.
- DEPTH = 4: offer 6 words → load_ready is low after the 4th word and load_overflow = 1. After load_done, prog_len = 4, and address 4 returns END_WORD.
- Assert load_start together with load_done mid-load, then load 2 new words → prog_len = 2 and load_overflow is cleared. Addresses 0–1 return the new words and address 2 returns END_WORD.
- Assert Reset after 5 words of a load → next cycle loading = 0 and prog_len = 0. Fetching address 0 returns END_WORD. fetch_en asserted during LOAD yields inst_valid = 0.
